rvv_backend_xrf_wb_arb: RTL and testbench
=========================================

# rvv_backend_xrf_wb_arb

Scalar (XRF) writeback arbiter between the retire stage and the RVS. Each cycle, up to `NUM_RT_UOP` retiring uops may produce scalar results (e.g. `vmv.x.s`, `vcpop.m`, `vfirst.m`). The RVS accepts one XRF write per cycle over a valid/ready port. The block queues results in program order, serialises them one per cycle toward the RVS, backpressures retire when it lacks space, and discards pending writes on a trap flush.

## Interface
- `NUM_RT_UOP`, 4, number of retire lanes; lane 0 is the oldest.
- `XLEN`, 32, scalar data width.
- `DEPTH`, 8, queue entries; power of two and ≥ `NUM_RT_UOP`.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rt_valid_i` in `NUM_RT_UOP`: per-lane scalar writeback request; lanes may be sparse.
- `rt_rd_i` in `NUM_RT_UOP*5`: per-lane destination XRF index; lane i is at bits [5i+4:5i].
- `rt_data_i` in `NUM_RT_UOP*XLEN`: per-lane scalar data.
- `rt_ready_o` out 1: whole group accepted when any `rt_valid_i` bit is set and this is high.
- `flush_i` in 1: trap flush; discards all queued and incoming writes.
- `xrf_valid_o` out 1: XRF write valid toward RVS.
- `xrf_rd_o` out 5: XRF write index.
- `xrf_data_o` out `XLEN`: XRF write data.
- `xrf_ready_i` in 1: RVS accepts the write.
- `occupancy_o` out `$clog2(DEPTH)+1`: current entry count.

## Operation
- Storage is a circular FIFO with `wr_ptr`, `rd_ptr` (`$clog2(DEPTH)` bits, wrapping mod `DEPTH`) and `count`.
- `rt_ready_o = !flush_i && (count <= DEPTH-NUM_RT_UOP)`. It does not depend on `rt_valid_i`, so the queue never overflows.
- Push: on acceptance, valid lanes are compacted in ascending lane order into slots `wr_ptr`, `wr_ptr+1`, … (mod `DEPTH`). `npush = popcount(rt_valid_i)` and `wr_ptr += npush`.
- Pop: when `xrf_valid_o && xrf_ready_i`, `rd_ptr += 1`.
- Count update: `count' = count + npush - pop`. Simultaneous push and pop in one cycle is legal, including with the queue full.
- Output: `xrf_valid_o = (count != 0)`, and `xrf_rd_o`/`xrf_data_o` come from slot `rd_ptr`. The output is held stable while `xrf_valid_o && !xrf_ready_i`.
- Flush:
  - A handshake on the output in the flush cycle completes normally.
  - All remaining entries are discarded.
  - `rt_ready_o` is 0 in the flush cycle, so no push occurs.
  - Next cycle: `count = 0` and `rd_ptr = wr_ptr`.
- Reset values: `count`, `wr_ptr`, `rd_ptr` = 0 and storage is not cleared. Outputs: `xrf_valid_o = 0`, `rt_ready_o = 1`, `occupancy_o = 0`. `xrf_rd_o`/`xrf_data_o` are don't-care while `xrf_valid_o = 0`.
- Reset asserted mid-operation drops all entries immediately, asynchronously.

## Timing
- Push-to-output latency is 1 cycle without bypass: a result accepted at edge N is visible on `xrf_valid_o` after edge N.
- Throughput is 1 XRF write per cycle at the output and up to `NUM_RT_UOP` writes per cycle at the input.
- Full boundary: at `count = DEPTH-NUM_RT_UOP+1`, `rt_ready_o` is low even if a pop occurs that cycle, because ready is based on pre-pop `count`.
- Empty boundary: at `count = 0` with no push, `xrf_valid_o = 0`. A pop and a push of 1 at `count = 1` leaves `count = 1`.
- Pointer wrap: a group straddling slot `DEPTH-1` → 0 stays in order.

## Configuration
- Macro: `RVV_XRF_WB_ARB_BYPASS_EN`.
- Without the macro: the behaviour above, with a minimum 1-cycle latency.
- With the macro, when `count = 0` and a group is accepted:
  - `xrf_valid_o`, `xrf_rd_o` and `xrf_data_o` are driven combinationally from the lowest valid lane.
  - If `xrf_ready_i` is also high, that lane is not stored: `npush` is reduced by 1 and the remaining lanes are compacted from `wr_ptr`.
  - This gives 0-cycle latency.
- Bypass never applies when `count != 0` or when `flush_i` is high, which preserves ordering.

## Test plan
- Reset, then `rt_valid_i=4'b1010`, lane 1 rd=3 data=0x11, lane 3 rd=7 data=0x22, `xrf_ready_i=1`:
  - Outputs are (3, 0x11) then (7, 0x22) on consecutive cycles.
  - `occupancy_o` goes 2 → 1 → 0.
- Hold `xrf_ready_i=0` and push 4 lanes (rd=1..4) twice:
  - The first group is accepted and `count = 4`.
  - The second group is accepted and `count = 8`, because `rt_ready_o` was 1 at `count = 4 ≤ DEPTH-NUM_RT_UOP = 4`.
  - After that, `rt_ready_o = 0`.
  - Output is held at rd=1 with stable data.
- Wrap: fill 6, drain 6, then push 4 (rd=10..13):
  - Slots 6, 7, 0, 1 are used.
  - Output order is 10, 11, 12, 13.
- With `count = 5`, `xrf_ready_i=1` and `flush_i` pulsed:
  - The head entry transfers in the flush cycle.
  - `xrf_valid_o = 0` and `occupancy_o = 0` the next cycle.
  - A group presented during the flush is not accepted.
- Assert `rst` mid-drain at `count = 3`:
  - `xrf_valid_o` drops immediately.
  - After release, `rt_ready_o = 1`.
- Bypass build, empty queue, push lane 0 (rd=5, 0xAB) with `xrf_ready_i=1`:
  - `xrf_valid_o = 1` with (5, 0xAB) in the same cycle.
  - `occupancy_o` stays 0.

Source files
------------

// File: rtl/rvv_backend_xrf_wb_arb_if.sv
// Retire-to-RVS scalar writeback bus for rvv_backend_xrf_wb_arb.
//   retire side : rt_valid_i / rt_rd_i / rt_data_i -> rt_ready_o, flush_i
//   RVS side    : xrf_valid_o / xrf_rd_o / xrf_data_o <- xrf_ready_i
//   status      : occupancy_o (current queue entry count)
// Modport 'slave' is the arbiter; 'master' is the surrounding pipeline.
interface rvv_backend_xrf_wb_arb_if #(
  parameter int unsigned NUM_RT_UOP = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 8
);
  logic [NUM_RT_UOP-1:0]      rt_valid_i;
  logic [NUM_RT_UOP*5-1:0]    rt_rd_i;
  logic [NUM_RT_UOP*XLEN-1:0] rt_data_i;
  logic                       rt_ready_o;
  logic                       flush_i;
  logic                       xrf_valid_o;
  logic [4:0]                 xrf_rd_o;
  logic [XLEN-1:0]            xrf_data_o;
  logic                       xrf_ready_i;
  logic [$clog2(DEPTH):0]     occupancy_o;

  modport master (
    output rt_valid_i, rt_rd_i, rt_data_i, flush_i, xrf_ready_i,
    input  rt_ready_o, xrf_valid_o, xrf_rd_o, xrf_data_o, occupancy_o
  );

  modport slave (
    input  rt_valid_i, rt_rd_i, rt_data_i, flush_i, xrf_ready_i,
    output rt_ready_o, xrf_valid_o, xrf_rd_o, xrf_data_o, occupancy_o
  );
endinterface

// File: rtl/rvv_backend_xrf_wb_arb.sv
// Scalar (XRF) writeback arbiter: queues up to NUM_RT_UOP retiring scalar
// results per cycle in program order (lane 0 oldest) and serialises them one
// per cycle toward the RVS. Trap flush discards everything queued.
// Ports: clk, rst (async, active-high), bus (rvv_backend_xrf_wb_arb_if.slave).
// Optional macro RVV_XRF_WB_ARB_BYPASS_EN: when the queue is empty, the oldest
// accepted lane is presented on the XRF port in the same cycle and is not
// stored if the RVS takes it.
module rvv_backend_xrf_wb_arb #(
  parameter int unsigned NUM_RT_UOP = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  rvv_backend_xrf_wb_arb_if.slave     bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - NUM_RT_UOP);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         npush;
  logic [4:0]            rd_mem_q   [DEPTH];
  logic [XLEN-1:0]       data_mem_q [DEPTH];
  logic [NUM_RT_UOP-1:0] lane_we;
  logic [NUM_RT_UOP-1:0] lane_skip;
  logic [PW-1:0]         lane_slot  [NUM_RT_UOP];
  logic                  rt_ready;
  logic                  accept;
  logic                  q_pop;
  logic                  xrf_valid;
  logic [4:0]            xrf_rd;
  logic [XLEN-1:0]       xrf_data;
`ifdef RVV_XRF_WB_ARB_BYPASS_EN
  logic                  byp_found;
`endif

  always_comb begin
    // Ready uses pre-pop count so it never depends on the RVS side.
    rt_ready  = !bus.flush_i && (count_q <= READY_MAX);
    accept    = rt_ready && (|bus.rt_valid_i);
    xrf_valid = (count_q != '0);
    xrf_rd    = rd_mem_q[rd_ptr_q];
    xrf_data  = data_mem_q[rd_ptr_q];
    lane_skip = '0;
`ifdef RVV_XRF_WB_ARB_BYPASS_EN
    byp_found = 1'b0;
    // accept already excludes flush, so bypass cannot reorder or leak on flush.
    if (accept && (count_q == '0)) begin
      xrf_valid = 1'b1;
      for (int unsigned i = 0; i < NUM_RT_UOP; i++) begin
        if (bus.rt_valid_i[i] && !byp_found) begin
          byp_found    = 1'b1;
          xrf_rd       = bus.rt_rd_i[5*i +: 5];
          xrf_data     = bus.rt_data_i[XLEN*i +: XLEN];
          lane_skip[i] = bus.xrf_ready_i;
        end
      end
    end
`endif
    q_pop = (count_q != '0) && bus.xrf_ready_i;

    // Compact valid lanes into consecutive slots starting at wr_ptr.
    npush   = '0;
    lane_we = '0;
    for (int unsigned i = 0; i < NUM_RT_UOP; i++) begin
      lane_slot[i] = wr_ptr_q + npush[PW-1:0];
      if (accept && bus.rt_valid_i[i] && !lane_skip[i]) begin
        lane_we[i] = 1'b1;
        npush      = npush + CW'(1);
      end
    end

    wr_ptr_d = wr_ptr_q + npush[PW-1:0];
    rd_ptr_d = rd_ptr_q + PW'(q_pop);
    count_d  = count_q + npush - CW'(q_pop);
    if (bus.flush_i) begin
      // No push is possible here (ready is low), so wr_ptr is already final.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_RT_UOP; i++) begin
      if (lane_we[i]) begin
        rd_mem_q[lane_slot[i]]   <= bus.rt_rd_i[5*i +: 5];
        data_mem_q[lane_slot[i]] <= bus.rt_data_i[XLEN*i +: XLEN];
      end
    end
  end

  assign bus.rt_ready_o  = rt_ready;
  assign bus.xrf_valid_o = xrf_valid;
  assign bus.xrf_rd_o    = xrf_rd;
  assign bus.xrf_data_o  = xrf_data;
  assign bus.occupancy_o = count_q;
endmodule

// File: tb/tb_rvv_backend_xrf_wb_arb.sv
module tb_rvv_backend_xrf_wb_arb;
  localparam int N = 4;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  wb_t  mdl_q[$];

  always #5 clk = ~clk;

  rvv_backend_xrf_wb_arb_if #(.NUM_RT_UOP(N), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  rvv_backend_xrf_wb_arb #(.NUM_RT_UOP(N), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_q.delete();
  endtask

  // One cycle: drive after posedge, check at negedge, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N*5-1:0] rd,
                      input logic [N*XLEN-1:0] d, input logic fl, input logic xr);
    logic exp_rdy, exp_vld, acc;
    logic [4:0] exp_rd;
    logic [XLEN-1:0] exp_data;
    int skip;
    wb_t e;
    @(posedge clk);
    #1;
    bus.rt_valid_i  = v;
    bus.rt_rd_i     = rd;
    bus.rt_data_i   = d;
    bus.flush_i     = fl;
    bus.xrf_ready_i = xr;
    #4;
    exp_rdy  = !fl && (mdl_q.size() <= DEPTH - N);
    acc      = exp_rdy && (v != '0);
    exp_vld  = (mdl_q.size() != 0);
    exp_rd   = '0;
    exp_data = '0;
    skip     = -1;
    if (exp_vld) begin
      exp_rd   = mdl_q[0].rd;
      exp_data = mdl_q[0].data;
    end
`ifdef RVV_XRF_WB_ARB_BYPASS_EN
    if (acc && mdl_q.size() == 0) begin
      exp_vld = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) begin
          exp_rd   = rd[5*i +: 5];
          exp_data = d[XLEN*i +: XLEN];
          skip     = xr ? i : -1;
        end
      end
    end
`endif
    check("rt_ready", 64'(bus.rt_ready_o), 64'(exp_rdy));
    check("xrf_valid", 64'(bus.xrf_valid_o), 64'(exp_vld));
    check("occupancy", 64'(bus.occupancy_o), 64'(mdl_q.size()));
    if (exp_vld) begin
      check("xrf_rd", 64'(bus.xrf_rd_o), 64'(exp_rd));
      check("xrf_data", 64'(bus.xrf_data_o), 64'(exp_data));
    end
    if (mdl_q.size() != 0 && xr) void'(mdl_q.pop_front());
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && i != skip) begin
          e.rd   = rd[5*i +: 5];
          e.data = d[XLEN*i +: XLEN];
          mdl_q.push_back(e);
        end
      end
    end
    if (fl) mdl_q.delete();
  endtask

  task automatic idle(input logic xr, input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0, xr);
  endtask

  initial begin
    logic [N*5-1:0]    rd_r;
    logic [N*XLEN-1:0] d_r;
    bus.rt_valid_i  = '0;
    bus.rt_rd_i     = '0;
    bus.rt_data_i   = '0;
    bus.flush_i     = 1'b0;
    bus.xrf_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", 64'(bus.xrf_valid_o), 64'd0);
    check("reset_ready", 64'(bus.rt_ready_o), 64'd1);
    check("reset_occ", 64'(bus.occupancy_o), 64'd0);

    // Sparse group: (3,0x11) then (7,0x22).
    step(4'b1010, {5'd7, 5'd0, 5'd3, 5'd0}, {32'h22, 32'h0, 32'h11, 32'h0}, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Fill to DEPTH with RVS stalled; third group must be refused.
    do_reset();
    step(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1'b0, 1'b0);
    step(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 1'b0, 1'b0);
    step(4'hf, {5'd9, 5'd9, 5'd9, 5'd9}, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 1'b0, 1'b0);
    step(4'h1, {5'd9, 5'd9, 5'd9, 5'd9}, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 1'b0, 1'b1);
    idle(1'b1, 9);

    // Full boundary: count 5 with a pop in the same cycle still refuses.
    do_reset();
    step(4'hf, {5'd1, 5'd2, 5'd3, 5'd4}, {32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 1'b0);
    step(4'h1, {5'd0, 5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h0, 32'h5}, 1'b0, 1'b0);
    step(4'h3, {5'd0, 5'd0, 5'd7, 5'd6}, {32'h0, 32'h0, 32'h7, 32'h6}, 1'b0, 1'b1);
    // Pop plus push of 1 at count 1 keeps count at 1.
    idle(1'b1, 3);
    step(4'h1, {5'd0, 5'd0, 5'd0, 5'd8}, {32'h0, 32'h0, 32'h0, 32'h8}, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Pointer wrap: fill 6, drain 6, push 4 into slots 6,7,0,1.
    do_reset();
    step(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
    step(4'h3, {5'd0, 5'd0, 5'd6, 5'd5}, {32'h0, 32'h0, 32'h6, 32'h5}, 1'b0, 1'b0);
    idle(1'b1, 6);
    step(4'hf, {5'd13, 5'd12, 5'd11, 5'd10}, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, 1'b0);
    idle(1'b1, 5);

    // Flush at count 5 with a group presented: head transfers, rest dropped.
    step(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
    step(4'h1, {5'd0, 5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h0, 32'h5}, 1'b0, 1'b0);
    step(4'hf, {5'd20, 5'd21, 5'd22, 5'd23}, {32'h20, 32'h21, 32'h22, 32'h23}, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Asynchronous reset mid-drain at count 3.
    step(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.rt_valid_i  = '0;
    bus.xrf_ready_i = 1'b1;
    check("pre_rst_occ", 64'(bus.occupancy_o), 64'd3);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.xrf_valid_o), 64'd0);
    check("async_rst_occ", 64'(bus.occupancy_o), 64'd0);
    mdl_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1, 1);

`ifdef RVV_XRF_WB_ARB_BYPASS_EN
    // Same-cycle bypass from empty.
    step(4'h1, {5'd0, 5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h0, 32'hAB}, 1'b0, 1'b1);
    idle(1'b1, 1);
    step(4'b0110, {5'd0, 5'd9, 5'd8, 5'd0}, {32'h0, 32'h99, 32'h88, 32'h0}, 1'b0, 1'b1);
    idle(1'b1, 2);
`endif

    // Randomized traffic with occasional flushes and varying backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        rd_r[5*i +: 5]       = 5'($urandom);
        d_r[XLEN*i +: XLEN]  = XLEN'($urandom);
      end
      step(N'($urandom), rd_r, d_r, ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) < ((c / 100) % 4)));
    end
    idle(1'b1, DEPTH + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
